prbs4_checker: RTL and testbench

- Receives the 4-bit pseudo-random word stream from the x^4+x+1 LFSR generator stage (one word per valid cycle).
- Checks that each word is the correct successor of the previous word, per the generator's update rule.
- Acquires and tracks sequence lock with a small state machine, and counts word errors for the link self-test.
- Sits directly downstream of the LFSR generator; its outputs go to status/debug logic.

---
 rtl/prbs4_checker.sv | 118 +++++++++++
 tb/tb_prbs4_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prbs4_checker.sv
// Checks the 4-bit x^4+x+1 LFSR word stream for correct succession,
// tracks sequence lock and counts word errors while locked.
module prbs4_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       data_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             zero_det,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             have_prev_q;
    logic [3:0]       prev_q;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             err_pulse_d;
    logic             zero_det_d;
    logic [ERR_W-1:0] err_count_d;

    logic [3:0] succ_c;
    logic       compare_c;
    logic       match_c;

    assign succ_c    = {prev_q[2:0], prev_q[3] ^ prev_q[0]};
    assign compare_c = valid_in && have_prev_q;
    // All-zero word never matches, so lock on the LFSR lock-up state is impossible
    assign match_c   = compare_c && (data_in == succ_c) && (data_in != 4'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            have_prev_q <= 1'b0;
            prev_q      <= 4'h0;
            good_q      <= '0;
            bad_q       <= '0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            zero_det    <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked    <= (state_d == ST_LOCKED);
            err_pulse <= err_pulse_d;
            zero_det  <= zero_det_d;
            err_count <= err_count_d;
            if (valid_in) begin
                have_prev_q <= 1'b1;
                prev_q      <= data_in;
            end
        end
    end

    // Lock state machine, counters and next-cycle output pulses
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        zero_det_d  = valid_in && (data_in == 4'h0);
        err_count_d = err_count;

        case (state_q)
            ST_SEARCH: begin
                if (match_c) begin
                    if (good_q == CNT_W'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + CNT_W'(1);
                    end
                end else if (compare_c) begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                if (match_c) begin
                    bad_d = '0;
                end else if (compare_c) begin
                    err_pulse_d = 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        err_count_d = err_count + ERR_W'(1);
                    end
                    if (bad_q == CNT_W'(LOSS_CNT - 1)) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        if (err_clr) begin
            err_count_d = '0;
        end
    end

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed + random bench for prbs4_checker; a behavioural model fills a
// scoreboard queue per instance and each cycle's outputs are checked.
module tb_prbs4_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [3:0] data_in;
    logic       err_clr;

    logic        locked0, err_pulse0, zero_det0;
    logic [15:0] err_count0;
    logic        locked1, err_pulse1, zero_det1;
    logic [1:0]  err_count1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs4_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .err_clr(err_clr), .locked(locked0), .err_pulse(err_pulse0),
        .zero_det(zero_det0), .err_count(err_count0)
    );

    prbs4_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) dut_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .err_clr(err_clr), .locked(locked1), .err_pulse(err_pulse1),
        .zero_det(zero_det1), .err_count(err_count1)
    );

    typedef struct {
        logic lk;
        logic ep;
        logic zd;
        int   cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Independent reference model, one slot per instance
    int m_lock_cnt[2] = '{4, 4};
    int m_loss_cnt[2] = '{3, 15};
    int m_max[2]      = '{65535, 3};
    int m_locked[2], m_have[2], m_prev[2], m_good[2], m_bad[2], m_cnt[2];

    function automatic int succ(int w);
        return ((w << 1) & 14) | (((w >> 3) ^ w) & 1);
    endfunction

    function automatic exp_t model(int i, logic r, logic v, int d, logic c);
        exp_t e;
        e.ep = 1'b0;
        e.zd = 1'b0;
        if (r) begin
            m_locked[i] = 0; m_have[i] = 0; m_prev[i] = 0;
            m_good[i] = 0; m_bad[i] = 0; m_cnt[i] = 0;
        end else begin
            if (v) begin
                e.zd = (d == 0);
                if (m_have[i] != 0) begin
                    if (m_locked[i] == 0) begin
                        if (d == succ(m_prev[i]) && d != 0) begin
                            m_good[i]++;
                            if (m_good[i] == m_lock_cnt[i]) begin
                                m_locked[i] = 1; m_good[i] = 0; m_bad[i] = 0;
                            end
                        end else m_good[i] = 0;
                    end else begin
                        if (d == succ(m_prev[i]) && d != 0) m_bad[i] = 0;
                        else begin
                            e.ep = 1'b1;
                            if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                            m_bad[i]++;
                            if (m_bad[i] == m_loss_cnt[i]) begin
                                m_locked[i] = 0; m_good[i] = 0; m_bad[i] = 0;
                            end
                        end
                    end
                end
                m_prev[i] = d;
                m_have[i] = 1;
            end
            if (c) m_cnt[i] = 0;
        end
        e.lk  = (m_locked[i] != 0);
        e.cnt = m_cnt[i];
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drive one cycle, queue expectations, then check after the edge
    task automatic step(logic r, logic v, logic [3:0] d, logic c);
        exp_t e0, e1;
        reset = r; valid_in = v; data_in = d; err_clr = c;
        q0.push_back(model(0, r, v, int'(d), c));
        q1.push_back(model(1, r, v, int'(d), c));
        @(posedge clk);
        #1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("locked",     32'(locked0),    32'(e0.lk));
        chk("err_pulse",  32'(err_pulse0), 32'(e0.ep));
        chk("zero_det",   32'(zero_det0),  32'(e0.zd));
        chk("err_count",  32'(err_count0), 32'(e0.cnt));
        chk("s_locked",   32'(locked1),    32'(e1.lk));
        chk("s_err_pulse",32'(err_pulse1), 32'(e1.ep));
        chk("s_zero_det", 32'(zero_det1),  32'(e1.zd));
        chk("s_err_count",32'(err_count1), 32'(e1.cnt));
    endtask

    task automatic word(logic [3:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        logic [3:0] w;
        reset = 1'b1; valid_in = 1'b0; data_in = 4'h0; err_clr = 1'b0;
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b0);

        // Acquire lock
        word(4'h1); word(4'h3); word(4'h7); word(4'hF); word(4'hE);
        // Zero word in place of a correct successor
        word(4'hD); word(4'h0); word(4'h5); word(4'hB);
        // Loss of lock, then relock
        word(4'h6); word(4'h6); word(4'h6); word(4'h6);
        word(4'hC); word(4'h9); word(4'h2); word(4'h4);
        // Bubbles between correct words
        step(1'b0, 1'b0, 4'h0, 1'b0);
        word(4'h8);
        step(1'b0, 1'b0, 4'h3, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        word(4'h1);
        // Clear concurrent with a mismatch, then clear alone
        step(1'b0, 1'b1, 4'h7, 1'b1);
        word(4'hF);
        word(4'h2);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        // Saturation run: five bad words
        word(4'h6); word(4'h6); word(4'h6); word(4'h6); word(4'h6);
        // Relock and build up errors, then reset mid-operation
        word(4'hC); word(4'h9); word(4'h2); word(4'h4); word(4'h8);
        word(4'h3); word(4'h3);
        step(1'b1, 1'b1, 4'h1, 1'b0);
        word(4'h0);
        word(4'h1); word(4'h3);

        // Mostly-correct random stream with random bubbles, errors and clears
        w = 4'h1;
        for (int i = 0; i < 200; i++) begin
            logic v, c, bad;
            v   = ($urandom_range(0, 5) != 0);
            c   = ($urandom_range(0, 30) == 0);
            bad = ($urandom_range(0, 7) == 0);
            if (v) begin
                if (bad) w = 4'($urandom_range(0, 15));
                else     w = 4'(succ(int'(w)) == 0 ? 1 : succ(int'(w)));
            end
            step(1'b0, v, w, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
